// File: rtl/cpu_debug_slave_cmd_engine.sv
// rtl/cpu_debug_slave_cmd_engine.sv - sysclk side of the CPU JTAG debug slave: strobe sync, command FIFO, action decode
module cpu_debug_slave_cmd_engine #(
  parameter int DR_W        = 38,
  parameter int IR_W        = 2,
  parameter int NUM_CH      = 4,
  parameter int ACT_BIT     = 34,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [IR_W-1:0]               ir_in,
  input  logic [DR_W-1:0]               sr,
  input  logic                          vs_uir,
  input  logic                          vs_udr,
  input  logic                          cmd_ready,
  input  logic                          clr_ovf,
  output logic                          cmd_valid,
  output logic [DR_W-1:0]               jdo,
  output logic [IR_W-1:0]               jdo_ir,
  output logic [NUM_CH-1:0]             take_action,
  output logic [NUM_CH-1:0]             take_no_action,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = IR_W + DR_W;

  // Synchroniser state. fill tracks which sync stages hold real samples
  // since reset, so a strobe held high through reset is never mistaken for
  // a low-to-high transition against the reset value of the chain.
  logic [SYNC_STAGES-1:0] uir_sync;
  logic [SYNC_STAGES-1:0] udr_sync;
  logic [SYNC_STAGES-1:0] fill;
  logic                   uir_prev;
  logic                   udr_prev;
  logic                   uir_armed;
  logic                   udr_armed;
  logic                   uir_s;
  logic                   udr_s;
  logic                   uir_evt;
  logic                   udr_evt;

  logic [IR_W-1:0]        ir_lat;

  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [LW-1:0]          count;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic                   wr_en;
  logic [EW-1:0]          head;
  logic [IR_W-1:0]        head_ir;
  logic [DR_W-1:0]        head_sr;

  assign uir_s   = uir_sync[SYNC_STAGES-1];
  assign udr_s   = udr_sync[SYNC_STAGES-1];
  assign uir_evt = uir_s & ~uir_prev & uir_armed;
  assign udr_evt = udr_s & ~udr_prev & udr_armed;

  assign full       = (count == LW'(FIFO_DEPTH));
  assign cmd_valid  = (count != '0);
  assign fifo_level = count;
  assign push       = udr_evt;
  assign pop        = cmd_valid & cmd_ready;
  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign wr_en      = push & (~full | pop);

  assign head    = mem[rd_ptr];
  assign head_ir = head[EW-1:DR_W];
  assign head_sr = head[DR_W-1:0];

  // Strobe synchronisers, edge history and arming
  always_ff @(posedge clk) begin
    if (reset) begin
      uir_sync  <= '0;
      udr_sync  <= '0;
      fill      <= '0;
      uir_prev  <= 1'b0;
      udr_prev  <= 1'b0;
      uir_armed <= 1'b0;
      udr_armed <= 1'b0;
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
      uir_prev <= uir_s;
      udr_prev <= udr_s;
      if (fill[SYNC_STAGES-1] && !uir_s) uir_armed <= 1'b1;
      if (fill[SYNC_STAGES-1] && !udr_s) udr_armed <= 1'b1;
    end
  end

  // Latch the virtual IR on each update-IR event
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_lat <= '0;
    end else if (uir_evt) begin
      ir_lat <= ir_in;
    end
  end

  // FIFO storage; contents are don't-care while not counted as occupied
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ir_lat, sr};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (push && full && !pop) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  // Pop: register the head command and issue its one-cycle channel pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      jdo            <= '0;
      jdo_ir         <= '0;
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      if (pop) begin
        jdo    <= head_sr;
        jdo_ir <= head_ir;
        for (int c = 0; c < NUM_CH; c++) begin
          if (head_ir == IR_W'(c)) begin
            take_action[c]    <= head_sr[ACT_BIT];
            take_no_action[c] <= ~head_sr[ACT_BIT];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_debug_slave_cmd_engine.sv
// tb/tb_cpu_debug_slave_cmd_engine.sv - randomized self-checking bench for cpu_debug_slave_cmd_engine
module tb_cpu_debug_slave_cmd_engine;

  localparam int DR_W    = 38;
  localparam int IR_W    = 2;
  localparam int NUM_CH  = 4;
  localparam int ACT_BIT = 34;
  localparam int DEPTH   = 4;

  typedef struct {
    logic [IR_W-1:0] ir;
    logic [DR_W-1:0] sr;
  } cmd_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [IR_W-1:0]   ir_in;
  logic [DR_W-1:0]   sr;
  logic              vs_uir;
  logic              vs_udr;
  logic              cmd_ready;
  logic              clr_ovf;
  logic              cmd_valid;
  logic [DR_W-1:0]   jdo;
  logic [IR_W-1:0]   jdo_ir;
  logic [NUM_CH-1:0] take_action;
  logic [NUM_CH-1:0] take_no_action;
  logic [2:0]        fifo_level;
  logic              ovf;

  int   tests = 0;
  int   fails = 0;
  cmd_t q[$];
  logic [IR_W-1:0] ir_m;
  bit   ovf_m;

  cpu_debug_slave_cmd_engine dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr), .vs_uir(vs_uir),
    .vs_udr(vs_udr), .cmd_ready(cmd_ready), .clr_ovf(clr_ovf),
    .cmd_valid(cmd_valid), .jdo(jdo), .jdo_ir(jdo_ir),
    .take_action(take_action), .take_no_action(take_no_action),
    .fifo_level(fifo_level), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_CH-1:0] exp_pulse(input cmd_t c, input bit act);
    if (int'(c.ir) >= NUM_CH) return '0;
    if (c.sr[ACT_BIT] != act) return '0;
    return NUM_CH'(1) << c.ir;
  endfunction

  function automatic logic [DR_W-1:0] rnd_sr();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[DR_W-1:0];
  endfunction

  task automatic do_uir(input logic [IR_W-1:0] v);
    ir_in  = v;
    vs_uir = 1'b1;
    tick(3);
    vs_uir = 1'b0;
    tick(3);
    ir_m = v;
  endtask

  // One update-DR with the consumer stalled; the model decides keep or drop.
  task automatic do_udr(input logic [DR_W-1:0] v);
    cmd_t c;
    sr     = v;
    vs_udr = 1'b1;
    tick(3);
    vs_udr = 1'b0;
    tick(3);
    c.ir = ir_m;
    c.sr = v;
    if (q.size() < DEPTH) q.push_back(c);
    else ovf_m = 1'b1;
    chk("level_after_push", 64'(fifo_level), 64'(q.size()));
    chk("ovf_after_push", 64'(ovf), 64'(ovf_m));
  endtask

  task automatic pop_one();
    cmd_t c;
    c = q.pop_front();
    chk("valid_before_pop", 64'(cmd_valid), 64'(1));
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("jdo", 64'(jdo), 64'(c.sr));
    chk("jdo_ir", 64'(jdo_ir), 64'(c.ir));
    chk("take_action", 64'(take_action), 64'(exp_pulse(c, 1'b1)));
    chk("take_no_action", 64'(take_no_action), 64'(exp_pulse(c, 1'b0)));
    chk("level_after_pop", 64'(fifo_level), 64'(q.size()));
    tick();
    chk("pulse_clear", 64'({take_action, take_no_action}), 64'(0));
  endtask

  initial begin
    logic [DR_W-1:0] s;
    cmd_t c;
    reset = 1'b1; ir_in = '0; sr = '0; vs_uir = 1'b0; vs_udr = 1'b0;
    cmd_ready = 1'b0; clr_ovf = 1'b0; ir_m = '0; ovf_m = 1'b0;
    tick(3);
    chk("rst_outputs", 64'({cmd_valid, jdo, jdo_ir, take_action, take_no_action, fifo_level, ovf}), 64'(0));
    reset = 1'b0;
    tick(5);

    // 1: action command for channel 1, exact latency
    do_uir(2'd1);
    s = rnd_sr();
    s[ACT_BIT] = 1'b1;
    sr = s; cmd_ready = 1'b1; vs_udr = 1'b1;
    tick(2);
    chk("t1_no_bypass", 64'(cmd_valid), 64'(0));
    tick();
    chk("t1_valid_edge2", 64'({cmd_valid, fifo_level}), 64'({1'b1, 3'd1}));
    tick();
    chk("t1_jdo", 64'(jdo), 64'(s));
    chk("t1_take_action", 64'({take_action, take_no_action}), 64'({4'b0010, 4'b0000}));
    chk("t1_level", 64'(fifo_level), 64'(0));
    tick();
    chk("t1_one_cycle", 64'(take_action), 64'(0));
    vs_udr = 1'b0; cmd_ready = 1'b0;
    tick(3);

    // 2: no-action command for channel 3
    do_uir(2'd3);
    s = rnd_sr();
    s[ACT_BIT] = 1'b0;
    do_udr(s);
    pop_one();

    // 3: overflow by five stalled updates, in-order drain, clear
    for (int i = 0; i < 5; i++) begin
      do_uir(IR_W'($urandom_range(0, 3)));
      do_udr(rnd_sr());
    end
    chk("t3_full", 64'({fifo_level, ovf}), 64'({3'd4, 1'b1}));
    while (q.size() > 0) pop_one();
    chk("t3_empty", 64'(cmd_valid), 64'(0));
    // Empty FIFO: cmd_ready must be ignored
    cmd_ready = 1'b1;
    tick(2);
    cmd_ready = 1'b0;
    chk("empty_no_pulse", 64'({take_action, take_no_action, fifo_level}), 64'(0));
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    ovf_m = 1'b0;
    chk("t3_clr_ovf", 64'(ovf), 64'(0));

    // 4: full FIFO, push and pop in the same cycle
    for (int i = 0; i < 4; i++) do_udr(rnd_sr());
    s = rnd_sr();
    sr = s; vs_udr = 1'b1;
    tick(2);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    c = q.pop_front();
    chk("t4_jdo", 64'(jdo), 64'(c.sr));
    chk("t4_level", 64'({fifo_level, ovf}), 64'({3'd4, 1'b0}));
    c.ir = ir_m; c.sr = s;
    q.push_back(c);
    vs_udr = 1'b0;
    tick(3);
    while (q.size() > 0) pop_one();

    // Randomised bursts
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) do_uir(IR_W'($urandom_range(0, 3)));
        do_udr(rnd_sr());
      end
      while (q.size() > 0) pop_one();
    end

    // 5: vs_udr held high across reset release
    vs_udr = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    ir_m = '0;
    tick(6);
    chk("t5_no_push_held", 64'({cmd_valid, fifo_level}), 64'(0));
    vs_udr = 1'b0;
    tick(4);
    s = rnd_sr();
    sr = s; vs_udr = 1'b1;
    tick(3);
    chk("t5_push_after_rearm", 64'(fifo_level), 64'(1));
    vs_udr = 1'b0;
    tick(3);
    c.ir = ir_m; c.sr = s;
    q.push_back(c);
    pop_one();

    // 6: reset with three queued entries
    for (int i = 0; i < 3; i++) do_udr(rnd_sr());
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    q.delete();
    chk("t6_flushed", 64'({cmd_valid, fifo_level}), 64'(0));
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_pulse", 64'({take_action, take_no_action, fifo_level, jdo}), 64'(0));
    end
    cmd_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
